depacketization: RTL and testbench
==================================

DEPACKETIZATION -- requirements
Module: depacketization

Interface
REQ-001 Parameter FLIT_DATA_WIDTH, default 32, payload bits per flit.
REQ-002 Parameter FLIT_TYPE_WIDTH, default 2, type field bits per flit.
REQ-003 Parameter FLIT_WIDTH, default FLIT_DATA_WIDTH+FLIT_TYPE_WIDTH, total flit width.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flit  input  FLIT_WIDTH  {type[FLIT_WIDTH-1:FLIT_DATA_WIDTH], data[FLIT_DATA_WIDTH-1:0]}.
REQ-007 valid  input  1  upstream flit valid.
REQ-008 ready  output  1  block accepts flit this cycle.
REQ-009 out_data  output  FLIT_DATA_WIDTH  payload word.
REQ-010 out_valid  output  1  out_data/out_sop/out_eop/out_len valid.
REQ-011 out_ready  input  1  downstream accepts word.
REQ-012 out_sop  output  1  word is first of packet.
REQ-013 out_eop  output  1  word is last of packet.
REQ-014 out_len  output  8  flits in packet so far including this word; meaningful when out_eop=1.
REQ-015 err  output  1  one-cycle pulse on protocol violation.
REQ-016 pkt_count  output  16  packets completed (eop words delivered), wraps at 65535->0.

Function
REQ-017 Flit types: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head and tail).
REQ-018 Handshake: flit accepted on posedge where valid=1 and ready=1; output word transferred where out_valid=1 and out_ready=1.
REQ-019 ready = !out_valid || out_ready (combinational, one-entry output register, no bubble at full throughput).
REQ-020 Latency: accepted flit appears on outputs the next cycle; out_* held stable while out_valid=1 and out_ready=0.
REQ-021 FSM states: IDLE (expect head/single), INPKT (expect body/tail).
REQ-022 IDLE + head: emit word sop=1 eop=0 len=1; go INPKT.
REQ-023 IDLE + single: emit sop=1 eop=1 len=1; stay IDLE.
REQ-024 IDLE + body or tail: flit accepted and dropped, no word emitted, err pulses, stay IDLE.
REQ-025 INPKT + body: emit sop=0 eop=0, len incremented; stay INPKT.
REQ-026 INPKT + tail: emit sop=0 eop=1, len incremented; go IDLE.
REQ-027 INPKT + head: err pulses; word emitted as new packet start (sop=1 eop=0 len=1); stay INPKT; previous packet not counted.
REQ-028 INPKT + single: err pulses; emit sop=1 eop=1 len=1; go IDLE.
REQ-029 Length counter saturates at 255; no wrap.
REQ-030 pkt_count increments on the cycle an eop word is transferred downstream.
REQ-031 err asserts the cycle after the offending flit is accepted, for exactly one cycle.
REQ-032 out_valid=0 and valid=0 simultaneously: state, counters unchanged.
REQ-033 Transfer out and accept in same cycle: new word replaces old with no gap.

Reset
REQ-034 While rst=1: state IDLE, out_valid=0, out_sop=0, out_eop=0, out_len=0, out_data=0, err=0, pkt_count=0, length counter 0.
REQ-035 ready=1 during and immediately after reset (out_valid=0).
REQ-036 Reset mid-packet discards the partial packet and pending output word; first flit after reset evaluated from IDLE.

Verification
REQ-037 out_ready=1; head data=1 then tail data=3 -> words (1,sop=1,eop=0,len=1),(3,sop=0,eop=1,len=2); pkt_count=1, err never asserted.
REQ-038 head, 3 body, tail back-to-back with out_ready=1 -> 5 consecutive words one cycle each, final len=5, ready constantly 1.
REQ-039 out_ready=0 while head arrives, next flit pending -> out_* held, ready=0, no flit lost; out_ready=1 resumes with no duplicate.
REQ-040 tail in IDLE -> no word, err pulse one cycle; following head/tail packet delivered normally.
REQ-041 head, body, then rst for one cycle, then single data=7 -> out_valid=0 after reset, then word (7,sop=1,eop=1,len=1), pkt_count=1.
REQ-042 300-flit packet (head, 298 body, tail) -> out_len=255 on tail word; pkt_count preset to 65535 wraps to 0.

Source files
------------

// File: rtl/depacketization.sv
// Flit-to-word depacketizer: strips the flit type field, marks packet boundaries,
// tracks packet length and counts delivered packets behind a one-entry output register.
module depacketization #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLIT_WIDTH-1:0]      flit,
    input  logic                       valid,
    output logic                       ready,
    output logic [FLIT_DATA_WIDTH-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [7:0]                 out_len,
    output logic                       err,
    output logic [15:0]                pkt_count
);

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        IDLE,
        INPKT
    } state_e;

    state_e                     state_q, state_d;
    logic [7:0]                 len_q, len_d;
    logic [FLIT_DATA_WIDTH-1:0] data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       sop_q, sop_d;
    logic                       eop_q, eop_d;
    logic [7:0]                 out_len_q, out_len_d;
    logic                       err_q, err_d;
    logic [15:0]                pkt_count_q, pkt_count_d;

    logic [FLIT_TYPE_WIDTH-1:0] type_field;
    flit_type_e                 flit_type;
    logic                       accept;
    logic                       transfer;
    logic [7:0]                 len_inc;
    logic                       emit;
    logic                       emit_sop;
    logic                       emit_eop;
    logic [7:0]                 emit_len;

    assign type_field = flit[FLIT_WIDTH-1:FLIT_DATA_WIDTH];
    assign flit_type  = flit_type_e'(type_field[1:0]);

    // The output register may be refilled in the same cycle it drains.
    assign ready    = !valid_q || out_ready;
    assign accept   = valid && ready;
    assign transfer = valid_q && out_ready;
    assign len_inc  = (len_q == 8'hFF) ? 8'hFF : len_q + 8'd1;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        len_d       = len_q;
        data_d      = data_q;
        valid_d     = valid_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        out_len_d   = out_len_q;
        err_d       = 1'b0;
        pkt_count_d = pkt_count_q;
        emit        = 1'b0;
        emit_sop    = 1'b0;
        emit_eop    = 1'b0;
        emit_len    = 8'd1;

        if (transfer) begin
            valid_d = 1'b0;
            if (eop_q) begin
                pkt_count_d = pkt_count_q + 16'd1;
            end
        end

        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    unique case (flit_type)
                        FT_HEAD: begin
                            emit     = 1'b1;
                            emit_sop = 1'b1;
                            state_d  = INPKT;
                        end
                        FT_SINGLE: begin
                            emit     = 1'b1;
                            emit_sop = 1'b1;
                            emit_eop = 1'b1;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
                INPKT: begin
                    unique case (flit_type)
                        FT_BODY: begin
                            emit     = 1'b1;
                            emit_len = len_inc;
                        end
                        FT_TAIL: begin
                            emit     = 1'b1;
                            emit_eop = 1'b1;
                            emit_len = len_inc;
                            state_d  = IDLE;
                        end
                        FT_HEAD: begin
                            // Restart: the unterminated packet is abandoned, never counted.
                            err_d    = 1'b1;
                            emit     = 1'b1;
                            emit_sop = 1'b1;
                        end
                        FT_SINGLE: begin
                            err_d    = 1'b1;
                            emit     = 1'b1;
                            emit_sop = 1'b1;
                            emit_eop = 1'b1;
                            state_d  = IDLE;
                        end
                    endcase
                end
            endcase
        end

        if (emit) begin
            valid_d   = 1'b1;
            data_d    = flit[FLIT_DATA_WIDTH-1:0];
            sop_d     = emit_sop;
            eop_d     = emit_eop;
            len_d     = emit_len;
            out_len_d = emit_len;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= 8'd0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            out_len_q   <= 8'd0;
            err_q       <= 1'b0;
            pkt_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            out_len_q   <= out_len_d;
            err_q       <= err_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign out_len   = out_len_q;
    assign err       = err_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_depacketization.sv
// Bench for depacketization: packet-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_depacketization;

    localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;

    typedef struct {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [7:0]  len;
        int          cyc;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [33:0] flit = '0;
    logic        valid = 1'b0;
    logic        ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sop;
    logic        out_eop;
    logic [7:0]  out_len;
    logic        err;
    logic [15:0] pkt_count;

    depacketization dut (
        .clk       (clk),
        .rst       (rst),
        .flit      (flit),
        .valid     (valid),
        .ready     (ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_len   (out_len),
        .err       (err),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    bit    cmp_en = 1'b0;
    bit    rand_or = 1'b0;
    int    err_cycles = 0;
    int    ready_low = 0;
    word_t log_q[$];

    // Reference model: output slot, packet-open flag, running length, delivered count.
    bit          m_vld = 1'b0;
    logic [31:0] m_data = '0;
    bit          m_sop = 1'b0;
    bit          m_eop = 1'b0;
    int          m_len = 0;
    int          m_run = 0;
    bit          m_in_pkt = 1'b0;
    bit          m_err = 1'b0;
    logic [15:0] m_cnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit accept;
        bit is_head;
        bit is_tail;
        cyc++;
        if (rst) begin
            m_vld = 0; m_in_pkt = 0; m_run = 0; m_err = 0; m_cnt = '0;
        end else begin
            accept = valid && (!m_vld || out_ready);
            if (m_vld && out_ready) begin
                if (m_eop) m_cnt = m_cnt + 16'd1;
                m_vld = 0;
            end
            m_err = 0;
            if (accept) begin
                is_head = (flit[33:32] == T_HEAD) || (flit[33:32] == T_SINGLE);
                is_tail = (flit[33:32] == T_TAIL) || (flit[33:32] == T_SINGLE);
                if (is_head || m_in_pkt) begin
                    if (is_head) begin
                        m_err = m_in_pkt;
                        m_run = 1;
                    end else begin
                        m_run = (m_run < 255) ? m_run + 1 : 255;
                    end
                    m_vld  = 1;
                    m_data = flit[31:0];
                    m_sop  = is_head;
                    m_eop  = is_tail;
                    m_len  = m_run;
                    m_in_pkt = !is_tail;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_valid", out_valid, m_vld);
            check("ready", ready, (!m_vld || out_ready));
            check("err", err, m_err);
            check("pkt_count", pkt_count, m_cnt);
            if (m_vld) begin
                check("out_data", out_data, m_data);
                check("out_sop", out_sop, m_sop);
                check("out_eop", out_eop, m_eop);
                check("out_len", out_len, m_len[7:0]);
            end
            if (err) err_cycles++;
            if (!ready) ready_low++;
            if (out_valid && out_ready)
                log_q.push_back('{d: out_data, sop: out_sop, eop: out_eop, len: out_len, cyc: cyc});
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [31:0] d);
        bit got = 0;
        flit  = {t, d};
        valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ready) begin
                got = 1;
                break;
            end
        end
        if (!got) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        log_q.delete();
        err_cycles = 0;
        ready_low = 0;
    endtask

    task automatic check_word(input string name, input int idx, input logic [31:0] d,
                              input logic sop, input logic eop, input logic [7:0] len);
        if (idx >= log_q.size()) begin
            check({name, "_present"}, 64'd0, 64'd1);
        end else begin
            check({name, "_data"}, log_q[idx].d, d);
            check({name, "_sop"}, log_q[idx].sop, sop);
            check({name, "_eop"}, log_q[idx].eop, eop);
            check({name, "_len"}, log_q[idx].len, len);
        end
    endtask

    initial begin
        // Reset state, sampled while rst is still high.
        idle(2);
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_ready", ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_sop", out_sop, 0);
        check("rst_out_eop", out_eop, 0);
        check("rst_out_len", out_len, 0);
        check("rst_err", err, 0);
        check("rst_pkt_count", pkt_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Head then tail.
        do_reset();
        send(T_HEAD, 32'd1);
        send(T_TAIL, 32'd3);
        idle(3);
        check("ht_words", log_q.size(), 2);
        check_word("ht_w0", 0, 32'd1, 1, 0, 8'd1);
        check_word("ht_w1", 1, 32'd3, 0, 1, 8'd2);
        check("ht_pkt_count", pkt_count, 16'd1);
        check("ht_err_cycles", err_cycles, 0);

        // Five-flit packet at full throughput.
        do_reset();
        send(T_HEAD, 32'h10);
        for (int i = 1; i <= 3; i++) send(T_BODY, 32'h10 + i);
        send(T_TAIL, 32'h14);
        idle(3);
        check("b2b_words", log_q.size(), 5);
        check_word("b2b_last", 4, 32'h14, 0, 1, 8'd5);
        if (log_q.size() == 5) check("b2b_span", log_q[4].cyc - log_q[0].cyc, 4);
        check("b2b_ready_low", ready_low, 0);

        // Backpressure with a pending flit.
        do_reset();
        out_ready = 1'b0;
        send(T_HEAD, 32'hA);
        flit  = {T_BODY, 32'hB};
        valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_data", out_data, 32'hA);
            check("bp_hold_sop", out_sop, 1);
            check("bp_ready", ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(T_BODY, 32'hB);
        send(T_TAIL, 32'hC);
        idle(3);
        check("bp_words", log_q.size(), 3);
        check_word("bp_w0", 0, 32'hA, 1, 0, 8'd1);
        check_word("bp_w1", 1, 32'hB, 0, 0, 8'd2);
        check_word("bp_w2", 2, 32'hC, 0, 1, 8'd3);

        // Tail while idle is dropped with a single error pulse.
        do_reset();
        send(T_TAIL, 32'h9);
        idle(3);
        check("orph_words", log_q.size(), 0);
        check("orph_err_cycles", err_cycles, 1);
        send(T_HEAD, 32'h4);
        send(T_TAIL, 32'h5);
        idle(3);
        check("orph_then_words", log_q.size(), 2);
        check_word("orph_then_w1", 1, 32'h5, 0, 1, 8'd2);
        check("orph_pkt_count", pkt_count, 16'd1);

        // Reset mid-packet.
        do_reset();
        send(T_HEAD, 32'h1);
        send(T_BODY, 32'h2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_pkt_count", pkt_count, 0);
        @(posedge clk);
        #1;
        log_q.delete();
        send(T_SINGLE, 32'h7);
        idle(3);
        check("mid_rst_words", log_q.size(), 1);
        check_word("mid_rst_w0", 0, 32'h7, 1, 1, 8'd1);
        check("mid_rst_pkt_count_after", pkt_count, 16'd1);

        // Counter wrap and length saturation.
        do_reset();
        for (int i = 0; i < 65535; i++) send(T_SINGLE, i);
        idle(2);
        check("wrap_pre_count", pkt_count, 16'hFFFF);
        log_q.delete();
        send(T_HEAD, 32'h100);
        for (int i = 0; i < 298; i++) send(T_BODY, 32'h200 + i);
        send(T_TAIL, 32'h300);
        idle(3);
        check("sat_words", log_q.size(), 300);
        check_word("sat_tail", 299, 32'h300, 0, 1, 8'd255);
        check("wrap_count", pkt_count, 16'd0);

        // Randomized traffic with random backpressure and protocol violations.
        do_reset();
        rand_or = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 9);
            logic [1:0] t;
            t = (r < 2) ? T_HEAD : (r < 7) ? T_BODY : (r < 9) ? T_TAIL : T_SINGLE;
            send(t, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_or = 1'b0;
        out_ready = 1'b1;
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
